// File: rtl/pulp_io_evt_queue_if.sv
// rtl/pulp_io_evt_queue_if.sv - event ID stream handshake between queue and consumer
interface pulp_io_evt_queue_if #(
  parameter int ID_W = 8
);
  logic            evt_valid_o;
  logic [ID_W-1:0] evt_data_o;
  logic            evt_ready_i;

  modport master (
    output evt_valid_o,
    output evt_data_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_data_o,
    output evt_ready_i
  );
endinterface

// File: rtl/pulp_io_evt_queue.sv
// rtl/pulp_io_evt_queue.sv - per-channel event counters, round-robin arbiter and output ID FIFO
module pulp_io_evt_queue #(
  parameter int N_CH    = 32,
  parameter int CNT_W   = 2,
  parameter int DEPTH   = 4,
  parameter int ID_W    = 8,
  parameter int ID_BASE = 0
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_ni,
  input  logic [N_CH-1:0]        evt_i,
  input  logic [N_CH-1:0]        evt_mask_i,
  input  logic                   clear_i,
  pulp_io_evt_queue_if.master    evt,
  output logic [N_CH-1:0]        overflow_o,
  input  logic [N_CH-1:0]        ovf_clr_i,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (ID_W < $clog2(N_CH)) begin : g_bad_id_w
    $error("pulp_io_evt_queue: ID_W too narrow for N_CH");
  end
  if ((1 << PTR_W) != DEPTH) begin : g_bad_depth
    $error("pulp_io_evt_queue: DEPTH must be a power of two");
  end

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  ovf_set;
  logic [N_CH-1:0]  ovf_q;
  logic [CH_W-1:0]  last_q;
  logic [CH_W-1:0]  gnt_idx;
  logic [CH_W-1:0]  hi_idx;
  logic [CH_W-1:0]  lo_idx;
  logic             hi_found;
  logic             lo_found;
  logic             gnt;
  logic             pop;
  logic             full;
  logic             valid;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req[c]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(c);
        if (c > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = CH_W'(c);
        end
      end
    end
  end

  assign gnt_idx = hi_found ? hi_idx : lo_idx;
  assign gnt_id  = ID_W'(ID_BASE + int'(gnt_idx));
  assign valid   = (level_q != '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop     = valid & evt.evt_ready_i;
  assign gnt     = lo_found & (~full | pop) & ~clear_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             inc;
    logic             dec;
    logic             sat;

    assign inc        = evt_i[c] & evt_mask_i[c] & ~clear_i;
    assign dec        = gnt & (gnt_idx == CH_W'(c));
    assign sat        = &cnt_q;
    assign req[c]     = evt_mask_i[c] & (|cnt_q);
    assign ovf_set[c] = inc & sat & ~dec;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
        cnt_q <= '0;
      end else if (clear_i) begin
        cnt_q <= '0;
      end else if (inc && !dec && !sat) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Round-robin pointer survives clear_i so fairness is not reset by a flush.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= CH_W'(N_CH - 1);
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (gnt) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        last_q   <= gnt_idx;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (gnt && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !gnt) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (gnt) begin
      mem_q[wr_ptr_q] <= gnt_id;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr_i) | ovf_set;
    end
  end

  assign evt.evt_valid_o = valid;
  assign evt.evt_data_o  = valid ? mem_q[rd_ptr_q] : '0;
  assign overflow_o      = ovf_q;
  assign level_o         = level_q;
endmodule

// File: tb/tb_pulp_io_evt_queue.sv
// tb/tb_pulp_io_evt_queue.sv - directed and randomized bench against a queue-based reference model
module tb_pulp_io_evt_queue;
  localparam int N    = 32;
  localparam int CW   = 2;
  localparam int D    = 4;
  localparam int IW   = 8;
  localparam int IB   = 0;
  localparam int CMAX = (1 << CW) - 1;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        evt;
  logic [N-1:0]        mask;
  logic [N-1:0]        ovf_clr;
  logic [N-1:0]        overflow;
  logic                clear;
  logic                ready;
  logic [$clog2(D):0]  level;

  pulp_io_evt_queue_if #(.ID_W(IW)) bus ();
  assign bus.evt_ready_i = ready;

  pulp_io_evt_queue #(
    .N_CH(N), .CNT_W(CW), .DEPTH(D), .ID_W(IW), .ID_BASE(IB)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .evt_i      (evt),
    .evt_mask_i (mask),
    .clear_i    (clear),
    .evt        (bus),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr),
    .level_o    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  int           cnt_m [N];
  int           q_m [$];
  int           last_m;
  logic [N-1:0] ovf_m;

  task automatic model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    q_m.delete();
    last_m = N - 1;
    ovf_m  = '0;
  endtask

  task automatic model_edge();
    bit           pop_m;
    bit           inc;
    bit           dec;
    int           g;
    int           c;
    logic [N-1:0] set_v;
    pop_m = (q_m.size() > 0) && ready;
    g     = -1;
    set_v = '0;
    if (clear) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      q_m.delete();
    end else begin
      if (q_m.size() < D || pop_m) begin
        for (int i = 1; i <= N; i++) begin
          c = (last_m + i) % N;
          if (g < 0 && mask[c] && cnt_m[c] > 0) g = c;
        end
      end
      for (int k = 0; k < N; k++) begin
        inc = evt[k] && mask[k];
        dec = (k == g);
        if (inc && !dec) begin
          if (cnt_m[k] < CMAX) cnt_m[k]++;
          else set_v[k] = 1'b1;
        end else if (dec && !inc) begin
          cnt_m[k]--;
        end
      end
      if (pop_m) void'(q_m.pop_front());
      if (g >= 0) begin
        q_m.push_back((IB + g) % (1 << IW));
        last_m = g;
      end
    end
    ovf_m = (ovf_m & ~ovf_clr) | set_v;
  endtask

  task automatic compare_model(input string pfx);
    check({pfx, "_valid"}, 64'(bus.evt_valid_o), 64'(q_m.size() > 0));
    check({pfx, "_data"}, 64'(bus.evt_data_o), (q_m.size() > 0) ? 64'(q_m[0]) : 64'd0);
    check({pfx, "_level"}, 64'(level), 64'(q_m.size()));
    check({pfx, "_ovf"}, 64'(overflow), 64'(ovf_m));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model("cyc");
    evt     = '0;
    clear   = 1'b0;
    ovf_clr = '0;
  endtask

  int n_pop;

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    evt     = '0;
    mask    = '1;
    ovf_clr = '0;
    clear   = 1'b0;
    ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single pulse on channel 5
    ready  = 1'b1;
    evt[5] = 1'b1;
    step();
    check("ch5_lat1_valid", 64'(bus.evt_valid_o), 64'd0);
    step();
    check("ch5_valid", 64'(bus.evt_valid_o), 64'd1);
    check("ch5_data", 64'(bus.evt_data_o), 64'd5);
    step();
    check("ch5_level_back", 64'(level), 64'd0);

    // simultaneous pulses, then round-robin continuation
    evt = 32'h7;
    step();
    step();
    check("rr_first", 64'(bus.evt_data_o), 64'd0);
    step();
    check("rr_second", 64'(bus.evt_data_o), 64'd1);
    step();
    check("rr_third", 64'(bus.evt_data_o), 64'd2);
    step();
    evt = 32'h5;
    step();
    step();
    check("rr_wrap_a", 64'(bus.evt_data_o), 64'd0);
    step();
    check("rr_wrap_b", 64'(bus.evt_data_o), 64'd2);
    step();

    // masked channel drops its pulses
    mask[7] = 1'b0;
    evt[7]  = 1'b1;
    step();
    evt[7] = 1'b1;
    step();
    mask = '1;
    repeat (4) step();
    check("mask_valid", 64'(bus.evt_valid_o), 64'd0);
    check("mask_level", 64'(level), 64'd0);

    // fill FIFO, saturate channel 3, then drain
    ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      evt[3] = 1'b1;
      step();
    end
    check("sat_level", 64'(level), 64'd4);
    check("sat_ovf3", 64'(overflow[3]), 64'd1);
    ready = 1'b1;
    n_pop = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.evt_valid_o) begin
        n_pop++;
        check("drain_data", 64'(bus.evt_data_o), 64'd3);
      end
      step();
      if (k == 0) check("full_pushpop_level", 64'(level), 64'd4);
      if (!bus.evt_valid_o) break;
    end
    check("drain_count", 64'(n_pop), 64'd7);

    // clear during queued traffic
    ready = 1'b0;
    repeat (3) begin
      evt = 32'h0000_0006;
      step();
    end
    clear = 1'b1;
    step();
    check("clear_level", 64'(level), 64'd0);
    check("clear_valid", 64'(bus.evt_valid_o), 64'd0);
    check("clear_keeps_ovf3", 64'(overflow[3]), 64'd1);

    // asynchronous reset mid-burst
    repeat (3) begin
      evt = 32'h0000_00f0;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.evt_valid_o), 64'd0);
    check("arst_data", 64'(bus.evt_data_o), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ready = 1'b1;
    repeat (3) step();
    check("post_rst_valid", 64'(bus.evt_valid_o), 64'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 50 == 0) begin
        mask = ($urandom_range(0, 2) == 0) ? ~($urandom & $urandom & $urandom) : '1;
      end
      evt     = $urandom & $urandom & $urandom;
      ready   = ($urandom_range(0, 3) != 0);
      clear   = ($urandom_range(0, 99) == 0);
      ovf_clr = ($urandom_range(0, 7) == 0) ? $urandom : '0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
